// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the external-interrupt controller.
// Contents: bus/id widths, register word offsets inside the 32-byte window,
// and the request FSM state type.
package irq_ctrl_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ID_W   = 4;

  // Byte offsets of the registers inside the window
  localparam logic [4:0] OFF_PENDING = 5'h00;
  localparam logic [4:0] OFF_MASK    = 5'h04;
  localparam logic [4:0] OFF_EDGE    = 5'h08;
  localparam logic [4:0] OFF_CLAIM   = 5'h0C;
  localparam logic [4:0] OFF_EOI     = 5'h10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    SERVICE = 2'd2
  } state_e;

endpackage

// File: rtl/irq_ctrl_if.sv
// Memory-stage register bus between the pipeline and the interrupt controller.
// Signals: addr (ALU result), wdata (store data), we (store strobe),
//          rdata (combinational read data), sel (address hits the window).
// master = pipeline side, slave = controller side.
interface irq_ctrl_if;
  import irq_ctrl_pkg::*;

  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              we;
  logic [DATA_W-1:0] rdata;
  logic              sel;

  modport master (output addr, output wdata, output we, input rdata, input sel);
  modport slave  (input addr, input wdata, input we, output rdata, output sel);

endinterface

// File: rtl/irq_ctrl_line_cond.sv
// Per-line input conditioning for one interrupt source.
// Ports: clk, rst_n (sync, active-low), line (device pin),
//        level_c (conditioned level s_irq), rise_c (rising edge of s_irq).
// Macro IRQ_CTRL_SYNC_EN: when defined, the pin passes a 2-flop synchronizer;
// when undefined, the pin is used directly (synchronous on-chip sources only).
module irq_line_cond (
  input  logic clk,
  input  logic rst_n,
  input  logic line,
  output logic level_c,
  output logic rise_c
);

`ifdef IRQ_CTRL_SYNC_EN
  logic [1:0] sync_q;

  // Two-stage synchronizer for asynchronous device pins
  always_ff @(posedge clk) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[0], line};
  end

  assign level_c = sync_q[1];
`else
  assign level_c = line;
`endif

  logic prev_q;

  // s_prev: conditioned level delayed by one cycle
  always_ff @(posedge clk) begin
    if (!rst_n) prev_q <= 1'b0;
    else        prev_q <= level_c;
  end

  assign rise_c = level_c & ~prev_q;

endmodule

// File: rtl/irq_ctrl.sv
// External-interrupt controller feeding the cop0 external-interrupt input.
// Ports: i_clk, i_rst_n (sync, active-low), i_irq[N_IRQ] device lines,
//        bus (irq_ctrl_if.slave: addr/wdata/we in, rdata/sel out, rdata combinational),
//        i_ack (cop0 took the external interrupt), o_irq (registered request),
//        o_irq_id (latched source id).
// Registers: 0x00 PENDING (W1C edge bits), 0x04 MASK, 0x08 EDGE, 0x0C CLAIM, 0x10 EOI.
// Macro IRQ_CTRL_SYNC_EN enables 2-flop input synchronizers (see irq_line_cond).
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int unsigned       N_IRQ     = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'hFFFF_0000
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [N_IRQ-1:0] i_irq,
  irq_ctrl_if.slave        bus,
  input  logic             i_ack,
  output logic             o_irq,
  output logic [ID_W-1:0]  o_irq_id
);

  logic [N_IRQ-1:0] s_irq, rise;
  logic [N_IRQ-1:0] pending_q, pending_d, mask_q, edge_mode_q;
  logic [N_IRQ-1:0] active, w1c, eoi_clr;
  logic [15:0]      active_ext;
  state_e           state_q, state_d;
  logic [ID_W-1:0]  id_q, id_d, lowest;
  logic             irq_d, claim_valid;
  logic             sel;
  logic [4:0]       off;
  logic             wr_pending, wr_mask, wr_edge, wr_eoi;
  logic             unused_wdata;

  // Line conditioning, one instance per source
  for (genvar g = 0; g < int'(N_IRQ); g++) begin : g_line
    irq_line_cond u_cond (
      .clk     (i_clk),
      .rst_n   (i_rst_n),
      .line    (i_irq[g]),
      .level_c (s_irq[g]),
      .rise_c  (rise[g])
    );
  end

  // Address decode; misaligned byte addresses map onto their word
  assign off        = {bus.addr[4:2], 2'b00};
  assign sel        = (bus.addr[31:5] == BASE_ADDR[31:5]) && (bus.addr[4:0] <= 5'h10);
  assign bus.sel    = sel;
  assign wr_pending = bus.we && sel && (off == OFF_PENDING);
  assign wr_mask    = bus.we && sel && (off == OFF_MASK);
  assign wr_edge    = bus.we && sel && (off == OFF_EDGE);
  assign wr_eoi     = bus.we && sel && (off == OFF_EOI);

  assign unused_wdata = ^bus.wdata[DATA_W-1:N_IRQ];

  // Clear sources for edge bits: software W1C and EOI of the serviced id
  always_comb begin
    w1c     = wr_pending ? bus.wdata[N_IRQ-1:0] : '0;
    eoi_clr = '0;
    for (int i = 0; i < int'(N_IRQ); i++) begin
      eoi_clr[i] = wr_eoi && (state_q == SERVICE) && (id_q == ID_W'(i));
    end
  end

  // Level bits follow the line; edge bits are sticky with set winning over clear
  assign pending_d = (edge_mode_q & (rise | (pending_q & ~(w1c | eoi_clr))))
                   | (~edge_mode_q & s_irq);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      pending_q   <= '0;
      mask_q      <= '0;
      edge_mode_q <= '0;
    end else begin
      pending_q <= pending_d;
      if (wr_mask) mask_q      <= bus.wdata[N_IRQ-1:0];
      if (wr_edge) edge_mode_q <= bus.wdata[N_IRQ-1:0];
    end
  end

  assign active     = pending_q & mask_q;
  assign active_ext = 16'(active);

  // Lowest active index has highest priority
  always_comb begin
    lowest = '0;
    for (int i = int'(N_IRQ) - 1; i >= 0; i--) begin
      if (active[i]) lowest = ID_W'(i);
    end
  end

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      id_q    <= '0;
      o_irq   <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      o_irq   <= irq_d;
    end
  end

  // FSM next state; ack beats retract in ASSERT
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    case (state_q)
      IDLE: begin
        if (|active) begin
          id_d    = lowest;
          state_d = ASSERT;
        end
      end
      ASSERT: begin
        if (i_ack)                    state_d = SERVICE;
        else if (!active_ext[id_q])   state_d = IDLE;
      end
      SERVICE: begin
        if (wr_eoi) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs; o_irq is registered from the next state
  always_comb begin
    irq_d       = (state_d == ASSERT);
    claim_valid = (state_q != IDLE);
  end

  assign o_irq_id = id_q;

  // Combinational read mux
  always_comb begin
    bus.rdata = '0;
    if (sel) begin
      case (off)
        OFF_PENDING: bus.rdata = DATA_W'(pending_q);
        OFF_MASK:    bus.rdata = DATA_W'(mask_q);
        OFF_EDGE:    bus.rdata = DATA_W'(edge_mode_q);
        OFF_CLAIM:   bus.rdata = claim_valid ? {1'b1, 27'b0, id_q} : '0;
        default:     bus.rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed scoreboard bench for irq_ctrl: stimulus pushes expected values,
// a negedge monitor pops and compares against the DUT outputs.
module tb_irq_ctrl;
  import irq_ctrl_pkg::*;

  localparam int unsigned N = 8;
  localparam logic [31:0] BASE = 32'hFFFF_0000;
`ifdef IRQ_CTRL_SYNC_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 0;
`endif

  localparam int K_RD  = 0;
  localparam int K_IRQ = 1;
  localparam int K_ID  = 2;
  localparam int K_SEL = 3;

  typedef struct {
    string       name;
    int          kind;
    logic [31:0] exp;
  } item_t;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   irq;
  logic           ack;
  logic           o_irq;
  logic [ID_W-1:0] o_irq_id;
  logic           chk_v;

  item_t sb[$];
  item_t cur;
  logic [31:0] act;
  int n_checks = 0;
  int n_fail   = 0;

  irq_ctrl_if bus ();

  irq_ctrl #(.N_IRQ(N), .BASE_ADDR(BASE)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_irq    (irq),
    .bus      (bus),
    .i_ack    (ack),
    .o_irq    (o_irq),
    .o_irq_id (o_irq_id)
  );

  always #5 clk = ~clk;

  // Monitor: compare one scoreboard entry per strobed cycle
  always @(negedge clk) begin
    if (chk_v) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_empty: check strobed with no expected value");
      end else begin
        cur = sb.pop_front();
        case (cur.kind)
          K_RD:    act = bus.rdata;
          K_IRQ:   act = {31'b0, o_irq};
          K_ID:    act = 32'(o_irq_id);
          default: act = {31'b0, bus.sel};
        endcase
        if (act !== cur.exp) begin
          n_fail++;
          $display("FAIL %s: got %h expected %h", cur.name, act, cur.exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.addr  = a;
    bus.wdata = d;
    bus.we    = 1'b1;
    tick();
    bus.we    = 1'b0;
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  task automatic pulse_irq(input logic [N-1:0] v);
    irq = v;
    tick();
    irq = '0;
    repeat (2 + SYNC) tick();
  endtask

  // Each check occupies exactly one clock cycle
  task automatic chk(input int kind, input logic [31:0] a, input logic [31:0] e, input string nm);
    item_t it;
    it.name = nm;
    it.kind = kind;
    it.exp  = e;
    bus.addr = a;
    bus.we   = 1'b0;
    sb.push_back(it);
    chk_v = 1'b1;
    @(negedge clk);
    #1;
    chk_v = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    irq       = '0;
    ack       = 1'b0;
    chk_v     = 1'b0;
    bus.addr  = '0;
    bus.wdata = '0;
    bus.we    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state
    chk(K_RD,  BASE + 32'h00, 32'h0, "rst_pending");
    chk(K_RD,  BASE + 32'h04, 32'h0, "rst_mask");
    chk(K_RD,  BASE + 32'h08, 32'h0, "rst_edge");
    chk(K_RD,  BASE + 32'h0C, 32'h0, "rst_claim");
    chk(K_IRQ, BASE, 32'h0, "rst_irq");
    chk(K_ID,  BASE, 32'h0, "rst_id");

    // Level source 0: latency, claim, ack, EOI, re-assert
    wr(BASE + 32'h04, 32'h01);
    wr(BASE + 32'h08, 32'h00);
    irq = 8'h01;
    chk(K_IRQ, BASE, 32'h0, "s1_lat0");
    chk(K_IRQ, BASE, 32'h0, "s1_lat1");
    repeat (SYNC) chk(K_IRQ, BASE, 32'h0, "s1_lat_sync");
    chk(K_IRQ, BASE, 32'h1, "s1_irq_high");
    chk(K_RD,  BASE + 32'h0C, 32'h8000_0000, "s1_claim");
    chk(K_ID,  BASE, 32'h0, "s1_id");
    pulse_ack();
    chk(K_IRQ, BASE, 32'h0, "s1_irq_after_ack");
    chk(K_RD,  BASE + 32'h0C, 32'h8000_0000, "s1_claim_service");
    pulse_ack();
    chk(K_IRQ, BASE, 32'h0, "s1_second_ack_ignored");
    wr(BASE + 32'h10, 32'h0);
    chk(K_IRQ, BASE, 32'h0, "s1_eoi_idle");
    chk(K_IRQ, BASE, 32'h1, "s1_reassert");
    irq = '0;
    repeat (2 + SYNC) tick();
    chk(K_IRQ, BASE, 32'h0, "s1_retract_level_low");
    chk(K_RD,  BASE + 32'h0C, 32'h0, "s1_claim_idle");

    // Edge mode, two sources pulsed together, priority and EOI clear
    wr(BASE + 32'h08, 32'hFF);
    wr(BASE + 32'h04, 32'hFF);
    pulse_irq(8'h24);
    chk(K_RD,  BASE + 32'h00, 32'h24, "s2_pending");
    chk(K_ID,  BASE, 32'h2, "s2_id2");
    chk(K_IRQ, BASE, 32'h1, "s2_irq");
    chk(K_RD,  BASE + 32'h0C, 32'h8000_0002, "s2_claim");
    pulse_ack();
    wr(BASE + 32'h10, 32'h0);
    chk(K_RD,  BASE + 32'h00, 32'h20, "s2_pending_after_eoi");
    chk(K_ID,  BASE, 32'h5, "s2_id5");
    chk(K_IRQ, BASE, 32'h1, "s2_irq_id5");

    // Retract on mask while asserting id 3
    pulse_ack();
    wr(BASE + 32'h10, 32'h0);
    pulse_irq(8'h08);
    chk(K_ID,  BASE, 32'h3, "s3_id3");
    chk(K_IRQ, BASE, 32'h1, "s3_irq");
    wr(BASE + 32'h04, 32'h00);
    chk(K_IRQ, BASE, 32'h1, "s3_irq_before_drop");
    chk(K_IRQ, BASE, 32'h0, "s3_irq_dropped");
    chk(K_RD,  BASE + 32'h0C, 32'h0, "s3_claim_idle");
    chk(K_RD,  BASE + 32'h00, 32'h08, "s3_pending_kept");

    // W1C versus simultaneous rising edge
    wr(BASE + 32'h00, 32'h08);
    chk(K_RD, BASE + 32'h00, 32'h00, "s4_w1c");
    pulse_irq(8'h02);
    chk(K_RD, BASE + 32'h00, 32'h02, "s4_pending1");
    irq = 8'h02;
    repeat (SYNC) tick();
    wr(BASE + 32'h00, 32'h02);
    chk(K_RD, BASE + 32'h00, 32'h02, "s4_set_wins");
    irq = '0;
    repeat (SYNC + 1) tick();
    wr(BASE + 32'h00, 32'h02);
    chk(K_RD, BASE + 32'h00, 32'h00, "s4_w1c_no_edge");

    // Reset while in SERVICE
    wr(BASE + 32'h04, 32'hFF);
    pulse_irq(8'h02);
    chk(K_IRQ, BASE, 32'h1, "s5_irq");
    chk(K_ID,  BASE, 32'h1, "s5_id1");
    pulse_ack();
    chk(K_RD,  BASE + 32'h0C, 32'h8000_0001, "s5_claim_service");
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk(K_RD,  BASE + 32'h00, 32'h0, "s5_pending");
    chk(K_RD,  BASE + 32'h04, 32'h0, "s5_mask");
    chk(K_RD,  BASE + 32'h08, 32'h0, "s5_edge");
    chk(K_RD,  BASE + 32'h0C, 32'h0, "s5_claim");
    chk(K_IRQ, BASE, 32'h0, "s5_irq_low");
    chk(K_ID,  BASE, 32'h0, "s5_id0");

    // Unmapped/read-only stores, window bounds, upper bits
    wr(BASE + 32'h18, 32'hFFFF_FFFF);
    chk(K_SEL, BASE + 32'h18, 32'h0, "s6_sel_0x18");
    chk(K_RD,  BASE + 32'h18, 32'h0, "s6_rdata_unsel");
    chk(K_RD,  BASE + 32'h04, 32'h0, "s6_mask_untouched");
    chk(K_RD,  BASE + 32'h08, 32'h0, "s6_edge_untouched");
    chk(K_RD,  BASE + 32'h00, 32'h0, "s6_pending_untouched");
    chk(K_SEL, BASE + 32'h10, 32'h1, "s6_sel_eoi");
    chk(K_SEL, BASE - 32'h4, 32'h0, "s6_sel_below");
    wr(BASE + 32'h04, 32'hFFFF_FFFF);
    chk(K_RD,  BASE + 32'h04, 32'h0000_00FF, "s6_mask_width");
    wr(BASE + 32'h0C, 32'hFFFF_FFFF);
    chk(K_RD,  BASE + 32'h0C, 32'h0, "s6_claim_ro");
    chk(K_IRQ, BASE, 32'h0, "s6_irq_quiet");

    tick();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover: got %0d entries expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
